// File: rtl/btn_event_arbiter_pkg.sv
// Shared types and helpers for the button event arbiter
// and other small round-robin arbiters.
package btn_event_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int TICK_DIV_100M = 250000;

    // First set bit of req[n-1:0], scanning ptr, ptr+1, ... with wrap at n.
    function automatic int unsigned rr_first_set(
        input logic [31:0] req,
        input int unsigned ptr,
        input int unsigned n
    );
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < 32; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[4:0]]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Shared slow-rate divider: one-cycle tick every TICK_DIV clocks.
module btn_tick_gen #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces buttons on a shared tick, latches presses as pending
// requests and offers them round-robin over a valid/ack handshake.
module btn_event_arbiter
    import btn_event_arbiter_pkg::*;
#(
    parameter int NUM_BTN  = 4,
    parameter int TICK_DIV = TICK_DIV_100M,
    parameter int IDX_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               evt_valid,
    output logic [IDX_W-1:0]   evt_idx,
    input  logic               evt_ack,
    input  logic               clr_ovr,
    output logic [NUM_BTN-1:0] pending,
    output logic [NUM_BTN-1:0] overrun
);

    logic tick;

    btn_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    logic [NUM_BTN-1:0] s0_q;
    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;
    logic               unused_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else if (tick) begin
            s0_q <= btn_raw;
            s1_q <= s0_q;
            s2_q <= s1_q;
        end
    end

    assign unused_s2 = ^s2_q;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               ack_fire;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] ovr_q, ovr_d;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] clr_mask;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        ack_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = OFFER;
                    idx_d   = IDX_W'(rr_first_set(32'(pend_q),
                                                  32'(rr_q), NUM_BTN));
                end
            end
            OFFER: begin
                if (evt_ack) begin
                    ack_fire = 1'b1;
                    state_d  = IDLE;
                    rr_d     = (idx_q == IDX_W'(NUM_BTN - 1)) ?
                               '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A press in the same cycle as its ack-clear keeps the bit set.
    always_comb begin
        clr_mask = '0;
        if (ack_fire) clr_mask[idx_q] = 1'b1;
        press  = {NUM_BTN{tick}} & s0_q & ~s1_q;
        pend_d = (pend_q & ~clr_mask) | press;
        ovr_d  = (clr_ovr ? '0 : ovr_q) | (press & pend_q & ~clr_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign evt_idx   = idx_q;
    assign pending   = pend_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed scenarios plus random
// stimulus, all checked against a cycle-level behavioural model.
module tb_btn_event_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic         evt_valid;
    logic [1:0]   evt_idx;
    logic         evt_ack;
    logic         clr_ovr;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .NUM_BTN (N),
        .TICK_DIV(TD),
        .IDX_W   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .evt_valid(evt_valid),
        .evt_idx  (evt_idx),
        .evt_ack  (evt_ack),
        .clr_ovr  (clr_ovr),
        .pending  (pending),
        .overrun  (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: cycles-since-reset phase, last two sampled levels,
    // pending/overrun flags, and the offered index (-1 = none).
    int m_cnt;
    bit m_last[N];
    bit m_prev[N];
    bit m_pend[N];
    bit m_ovr[N];
    int m_offer;
    int m_ptr;

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] ovr_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_ovr[i];
        return v;
    endfunction

    function automatic void model_step(logic r, logic [N-1:0] b,
                                       logic a, logic c);
        bit tk;
        bit pre[N];
        bit prs[N];
        int cleared;
        bit any;
        if (r) begin
            m_cnt = 0;
            m_offer = -1;
            m_ptr = 0;
            for (int i = 0; i < N; i++) begin
                m_last[i] = 0; m_prev[i] = 0;
                m_pend[i] = 0; m_ovr[i] = 0;
            end
            return;
        end
        tk = (m_cnt == TD - 1);
        m_cnt = (m_cnt + 1) % TD;
        cleared = (m_offer >= 0 && a) ? m_offer : -1;
        any = 0;
        for (int i = 0; i < N; i++) begin
            pre[i] = m_pend[i];
            any |= pre[i];
            prs[i] = tk && m_last[i] && !m_prev[i];
        end
        for (int i = 0; i < N; i++) begin
            bit lost;
            lost = prs[i] && pre[i] && (i != cleared);
            m_ovr[i] = (c ? 1'b0 : m_ovr[i]) | lost;
            if (prs[i]) m_pend[i] = 1;
            else if (i == cleared) m_pend[i] = 0;
            if (tk) begin
                m_prev[i] = m_last[i];
                m_last[i] = b[i];
            end
        end
        if (m_offer >= 0) begin
            if (a) begin
                m_ptr = (m_offer + 1) % N;
                m_offer = -1;
            end
        end else if (any) begin
            for (int k = N - 1; k >= 0; k--) begin
                int j;
                j = (m_ptr + k) % N;
                if (pre[j]) m_offer = j;
            end
        end
    endfunction

    string phase = "init";

    task automatic run(int n);
        repeat (n) begin
            model_step(reset, btn_raw, evt_ack, clr_ovr);
            @(posedge clk);
            @(negedge clk);
            check({phase, "_valid"}, 32'(evt_valid), 32'(m_offer >= 0));
            if (m_offer >= 0)
                check({phase, "_idx"}, 32'(evt_idx), m_offer);
            check({phase, "_pend"}, 32'(pending), 32'(pend_vec()));
            check({phase, "_ovr"}, 32'(overrun), 32'(ovr_vec()));
        end
    endtask

    task automatic wait_valid(int max, string tag);
        int k = 0;
        while (!evt_valid && k < max) begin
            run(1);
            k++;
        end
        check({tag, "_timeout"}, 32'(evt_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        btn_raw = 4'hF;
        evt_ack = 1'b0;
        clr_ovr = 1'b0;
        @(negedge clk);

        phase = "rst";
        run(3);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_ovr", 32'(overrun), 0);
        reset = 1'b0;

        phase = "single";
        btn_raw = 4'b0010;
        run(8);
        check("sp_pend_at_tick2", 32'(pending), 32'h2);
        check("sp_valid_at_tick2", 32'(evt_valid), 0);
        run(1);
        check("sp_valid_next", 32'(evt_valid), 1);
        check("sp_idx", 32'(evt_idx), 1);
        run(3);
        evt_ack = 1'b1;
        run(1);
        evt_ack = 1'b0;
        check("sp_pend_acked", 32'(pending), 0);
        check("sp_valid_acked", 32'(evt_valid), 0);
        btn_raw = '0;
        run(12);

        phase = "glitch";
        while (m_cnt != 0) run(1);
        btn_raw = 4'b0001;
        run(2);
        btn_raw = '0;
        run(12);
        check("gl_pend", 32'(pending), 0);
        check("gl_valid", 32'(evt_valid), 0);

        phase = "rr";
        do_reset();
        btn_raw = 4'b0101;
        wait_valid(40, "rr1");
        check("rr_first", 32'(evt_idx), 0);
        evt_ack = 1'b1; run(1); evt_ack = 1'b0;
        wait_valid(10, "rr2");
        check("rr_second", 32'(evt_idx), 2);
        evt_ack = 1'b1; run(1); evt_ack = 1'b0;
        btn_raw = '0;
        run(12);
        btn_raw = 4'b0101;
        wait_valid(40, "rr3");
        check("rr_wrap", 32'(evt_idx), 0);
        evt_ack = 1'b1; run(1); evt_ack = 1'b0;
        run(4);

        phase = "ovr";
        do_reset();
        btn_raw = 4'b1000; run(12);
        btn_raw = '0;      run(12);
        btn_raw = 4'b1000; run(12);
        check("ov_flag", 32'(overrun), 32'h8);
        check("ov_pend", 32'(pending), 32'h8);
        check("ov_idx", 32'(evt_idx), 3);
        evt_ack = 1'b1; run(1); evt_ack = 1'b0;
        check("ov_pend_acked", 32'(pending), 0);
        run(20);
        check("ov_one_event", 32'(evt_valid), 0);
        clr_ovr = 1'b1; run(1); clr_ovr = 1'b0;
        check("ov_cleared", 32'(overrun), 0);

        phase = "rstoffer";
        btn_raw = 4'b0001;
        wait_valid(40, "ro");
        btn_raw = '0;
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("ro_valid", 32'(evt_valid), 0);
        check("ro_pend", 32'(pending), 0);
        run(20);
        check("ro_quiet", 32'(evt_valid), 0);

        phase = "rand";
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) btn_raw[i] = ~btn_raw[i];
            if (cyc < 2000) evt_ack = 1'($urandom_range(0, 1));
            else evt_ack = ($urandom_range(0, 15) == 0);
            clr_ovr = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 499) == 0);
            run(1);
        end
        reset = 1'b0;
        evt_ack = 1'b0;
        clr_ovr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
